// File: rtl/alu_status_unit_pkg.sv
// Shared types for the ALU status stage: flag indices, flag vector and buffer states.
package alu_status_unit_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Masked flag update: enabled bits take the computed value, others hold.
  function automatic flags_t merge_flags(flags_t cur, flags_t comp, flags_t mask);
    return (comp & mask) | (cur & ~mask);
  endfunction

endpackage

// File: rtl/alu_status_unit_if.sv
// ALU-result input channel and writeback output channel of the status stage.
interface alu_status_unit_if #(
  parameter int unsigned w = 16
);
  import alu_status_unit_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [w-1:0] in_result;
  logic         in_carry;
  logic         in_ovf;
  flags_t       in_mask;
  logic         out_valid;
  logic         out_ready;
  logic [w-1:0] out_result;
  flags_t       out_flags;

  modport master (
    output in_valid, in_result, in_carry, in_ovf, in_mask, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_carry, in_ovf, in_mask, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/or_tree.sv
// OR-reduction tree; any_c is high when at least one input bit is set.
module or_tree #(
  parameter int unsigned w = 16
) (
  input  logic [w-1:0] data,
  output logic         any_c
);

  assign any_c = |data;

endmodule

// File: rtl/alu_status_unit.sv
// Flag generation, architectural/sticky flag registers and a 2-entry
// valid/ready result buffer between the ALU and writeback.
module alu_status_unit
  import alu_status_unit_pkg::*;
#(
  parameter int unsigned w     = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_status_unit_if.slave bus,
  input  logic             sticky_clr,
  output flags_t           sticky,
  output logic [CNT_W-1:0] op_count
);

  buf_state_t       state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  flags_t           flags_q;
  flags_t           sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q;
  logic [w-1:0]     head_result_q, head_result_d;
  flags_t           head_flags_q, head_flags_d;
  logic [w-1:0]     tail_result_q, tail_result_d;
  flags_t           tail_flags_q, tail_flags_d;

  logic   nonzero_c;
  logic   accept_c;
  logic   pop_c;
  flags_t comp_c;
  flags_t flags_new_c;
  flags_t upd_c;

  or_tree #(.w(w)) u_or_tree (
    .data  (bus.in_result),
    .any_c (nonzero_c)
  );

  always_comb begin
    comp_c         = '0;
    comp_c[FLAG_Z] = ~nonzero_c;
    comp_c[FLAG_N] = bus.in_result[w-1];
    comp_c[FLAG_C] = bus.in_carry;
    comp_c[FLAG_V] = bus.in_ovf;
  end

  assign accept_c    = bus.in_valid & in_ready_q;
  assign pop_c       = out_valid_q & bus.out_ready;
  assign flags_new_c = merge_flags(flags_q, comp_c, bus.in_mask);
  assign upd_c       = comp_c & bus.in_mask;

  // Clear takes effect before a same-cycle accept ORs in its flags.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = accept_c ? upd_c : '0;
    end else if (accept_c) begin
      sticky_d = sticky_q | upd_c;
    end
  end

  // Buffer next-state and entry movement; head is always the oldest entry.
  always_comb begin
    state_d       = state_q;
    head_result_d = head_result_q;
    head_flags_d  = head_flags_q;
    tail_result_d = tail_result_q;
    tail_flags_d  = tail_flags_q;
    unique case (state_q)
      EMPTY: begin
        if (accept_c) begin
          state_d       = ONE;
          head_result_d = bus.in_result;
          head_flags_d  = flags_new_c;
        end
      end
      ONE: begin
        if (accept_c && pop_c) begin
          head_result_d = bus.in_result;
          head_flags_d  = flags_new_c;
        end else if (accept_c) begin
          state_d       = FULL;
          tail_result_d = bus.in_result;
          tail_flags_d  = flags_new_c;
        end else if (pop_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop_c) begin
          state_d       = ONE;
          head_result_d = tail_result_q;
          head_flags_d  = tail_flags_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      flags_q       <= '0;
      sticky_q      <= '0;
      op_count_q    <= '0;
      head_result_q <= '0;
      head_flags_q  <= '0;
      tail_result_q <= '0;
      tail_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= (state_d != FULL);
      out_valid_q   <= (state_d != EMPTY);
      sticky_q      <= sticky_d;
      head_result_q <= head_result_d;
      head_flags_q  <= head_flags_d;
      tail_result_q <= tail_result_d;
      tail_flags_q  <= tail_flags_d;
      if (accept_c) begin
        flags_q    <= flags_new_c;
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = head_result_q;
  assign bus.out_flags  = head_flags_q;
  assign sticky         = sticky_q;
  assign op_count       = op_count_q;

endmodule

// File: doc/alu_status_unit.md
# alu_status_unit

Registered flag-generation and result-buffering stage placed directly downstream of the ALU datapath. It consumes each ALU result, derives Z/N/C/V, and applies a per-operation update mask to the architectural flag register. It keeps sticky (accumulated) flags and hands result+flags to the writeback stage through a 2-entry valid/ready buffer. Zero detection is the consumer of the existing OR-reduction tree.

## Interface
Parameters:
- w, 16, ALU result width (≥2)
- CNT_W, 16, width of accepted-operation counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ALU result present
- in_ready  out  1  stage can accept (registered)
- in_result  in  w  ALU result
- in_carry  in  1  carry-out from ALU adder
- in_ovf  in  1  signed overflow from ALU
- in_mask  in  4  flag update enables {Z,N,C,V} = bits [3:0]
- out_valid  out  1  buffered entry available
- out_ready  in  1  writeback accepts
- out_result  out  w  head-entry result
- out_flags  out  4  head-entry architectural flags {Z,N,C,V}
- sticky  out  4  OR of all updated flags since last clear
- sticky_clr  in  1  clear sticky flags
- op_count  out  CNT_W  accepted-operation count

## Operation
- Accept = in_valid & in_ready. Only accepted ops change state.
- Computed flags: Z = ~(OR of in_result), N = in_result[w-1], C = in_carry, V = in_ovf.
- Architectural flag register F: on accept, F[i] <= in_mask[i] ? computed[i] : F[i]. The new F is pushed with in_result.
- Flag chaining is in acceptance order. Op k sees F as updated by op k-1, even if op k-1 is still buffered.
- Sticky S: on accept, S |= (computed & in_mask).
  - sticky_clr without accept: S <= 0.
  - sticky_clr with accept: S <= computed & in_mask. The clear applies first.
- op_count increments on each accept. It wraps from 2^CNT_W-1 to 0.
- Output buffer FSM, states EMPTY / ONE / FULL. Push = accept; pop = out_valid & out_ready.
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE, new entry becomes head.
  - FULL: pop → ONE. Push is impossible because in_ready=0.
- in_ready = 1 in EMPTY/ONE and 0 in FULL. It is registered from the next state.
- out_valid = state ≠ EMPTY. out_result/out_flags show the head entry and stay stable while out_valid & ~out_ready.
- Reset values: state EMPTY, out_valid 0, in_ready 1, out_result 0, out_flags 0, F 0, S 0, op_count 0.
- Reset mid-operation: buffered entries are discarded with no pop. rst overrides any simultaneous accept, pop or sticky_clr.

## Timing
- Latency: accept at edge n → out_valid=1 with that entry after edge n (visible in cycle n+1).
- Throughput: 1 op/cycle sustained while out_ready=1.
- With out_ready=0, two ops are absorbed. in_ready falls in the cycle after the second accept.
- From FULL, one pop raises in_ready in the next cycle. The pop cycle itself does not accept (no combinational ready path).
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- sticky, op_count and F update at the same edge as the accept.

## Structure
- Shared package holds:
  - flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0
  - the 4-bit flag vector typedef
  - buffer state encoding EMPTY/ONE/FULL
- One sub-module is natural: or_tree (parameter w) for the nonzero detect. Z is its inverted output.
- The 2-entry buffer stays inline. Splitting it out is permitted only as alu_status_buf.

## Test plan
- Reset then idle: after rst, in_ready=1, out_valid=0, op_count=0, sticky=0000, out_flags=0000.
- Zero/negative detect, w=16, mask=1111, out_ready=1: result 0x0000 c=0 v=0 → next cycle flags 1000. Then 0x8000 c=1 v=1 → flags 0111. op_count=2.
- Masked update: F=1000, accept 0xFFFF c=1 with mask=0010 → flags 1010 (only C changes). sticky=1010 after the prior zero op.
- Backpressure: out_ready=0, push 0x0001, 0x0002, 0x0003 on consecutive cycles.
  - Only two are accepted; in_ready=0 from the third cycle.
  - Raise out_ready → 0x0001 then 0x0002 in order; in_ready returns one cycle after the first pop.
- Sticky clear collision: S=1000, same-cycle sticky_clr and accept of 0x8000 mask=1111 c=0 v=0 → sticky=0100.
- Counter wrap and reset mid-op, CNT_W=4:
  - 16 accepts → op_count=0.
  - Assert rst while FULL → next cycle out_valid=0, in_ready=1, all state zero.
